// File: rtl/mm_pkg.sv
// Shared sizing, FSM states and FIFO payload for the matrix-multiplier result drain.
package mm_pkg;

  localparam int unsigned DIM    = 8;
  localparam int unsigned IDX_W  = $clog2(DIM);
  localparam int unsigned DATA_W = 19;
  localparam int unsigned ADDR_W = 2 * IDX_W;
  localparam int unsigned CHK_W  = DATA_W + ADDR_W;
  localparam int unsigned N_ELEM = DIM * DIM;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } drain_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic              last;
  } fifo_entry_t;

endpackage

// File: rtl/drain_fifo2.sv
// Two-entry synchronous FIFO carrying result elements with their row/col/last tags.
module drain_fifo2
  import mm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_push,
  input  fifo_entry_t i_din,
  input  logic        i_pop,
  output fifo_entry_t o_dout,
  output logic        o_full,
  output logic        o_empty,
  output logic [1:0]  o_count
);

  fifo_entry_t r_mem [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;
  logic        w_push;
  logic        w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  // A push into a full FIFO is honoured only when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/result_drain.sv
// Reads the column-major result RAM after the multiplier finishes and streams it
// out (row-major by default) with tags, a last flag and a running signed checksum.
module result_drain
  import mm_pkg::*;
#(
  parameter bit ROW_MAJOR = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic              out_last,
  output logic [CHK_W-1:0]  checksum
);

  drain_state_t      r_state;
  drain_state_t      w_state_nxt;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_rd_idx;
  logic              r_pend;
  logic [IDX_W-1:0]  r_pend_row;
  logic [IDX_W-1:0]  r_pend_col;
  logic              r_pend_last;
  logic [CHK_W-1:0]  r_checksum;

  logic [IDX_W-1:0]  w_row;
  logic [IDX_W-1:0]  w_col;
  logic              w_start_acc;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [1:0]        w_fifo_count;
  logic [2:0]        w_load;
  fifo_entry_t       w_head;
  fifo_entry_t       w_push_entry;

  // Both orders place element (r,c) at address {c,r}; only the index split differs.
  assign w_row    = ROW_MAJOR ? r_rd_idx[ADDR_W-1:IDX_W] : r_rd_idx[IDX_W-1:0];
  assign w_col    = ROW_MAJOR ? r_rd_idx[IDX_W-1:0]      : r_rd_idx[ADDR_W-1:IDX_W];
  assign ram_addr = {w_col, w_row};

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_pop       = !w_fifo_empty && out_ready;

  // Issue only while occupancy after this cycle's pop plus the read in flight leaves a free slot.
  assign w_load    = 3'(w_fifo_count) + 3'(r_pend);
  assign ram_rd_en = (r_state == RUN) && !(w_fifo_full && !w_pop) &&
                     (w_load < (3'd2 + 3'(w_pop)));

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.data = ram_rd_data;
    w_push_entry.row  = r_pend_row;
    w_push_entry.col  = r_pend_col;
    w_push_entry.last = r_pend_last;
  end

  drain_fifo2 u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_pend),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
      r_done  <= (w_state_nxt == FIN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (ram_rd_en && (r_rd_idx == ADDR_W'(N_ELEM - 1))) w_state_nxt = DRAIN;
      DRAIN:   if (w_pop && w_head.last && (w_fifo_count == 2'd1) && !r_pend) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read pipeline tags and the checksum accumulator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_idx    <= '0;
      r_pend      <= 1'b0;
      r_pend_row  <= '0;
      r_pend_col  <= '0;
      r_pend_last <= 1'b0;
      r_checksum  <= '0;
    end else begin
      r_pend      <= ram_rd_en;
      r_pend_row  <= w_row;
      r_pend_col  <= w_col;
      r_pend_last <= (r_rd_idx == ADDR_W'(N_ELEM - 1));
      if (w_start_acc) begin
        r_rd_idx <= '0;
      end else if (ram_rd_en) begin
        r_rd_idx <= r_rd_idx + ADDR_W'(1);
      end
      if (w_start_acc) begin
        r_checksum <= '0;
      end else if (w_pop) begin
        r_checksum <= r_checksum + {{(CHK_W - DATA_W){w_head.data[DATA_W-1]}}, w_head.data};
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign checksum  = r_checksum;
  assign out_valid = !w_fifo_empty;
  assign out_data  = out_valid ? w_head.data : '0;
  assign out_row   = out_valid ? w_head.row  : '0;
  assign out_col   = out_valid ? w_head.col  : '0;
  assign out_last  = out_valid && w_head.last;

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: table of stream scenarios checked against a
// behavioural model of the RAM readout order, plus a plain-order instance.
module tb_result_drain;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, done, ram_rd_en, out_valid, out_last;
  logic [5:0]  ram_addr;
  logic [18:0] ram_rd_data = '0;
  logic [18:0] out_data;
  logic [2:0]  out_row, out_col;
  logic [24:0] checksum;

  logic        start2 = 1'b0;
  logic        out_ready2 = 1'b1;
  logic        busy2, done2, ram_rd_en2, out_valid2, out_last2;
  logic [5:0]  ram_addr2;
  logic [18:0] ram_rd_data2 = '0;
  logic [18:0] out_data2;
  logic [2:0]  out_row2, out_col2;
  logic [24:0] checksum2;

  logic [18:0] mem  [64];
  logic [18:0] mem2 [64];

  always #5 clk = ~clk;

  result_drain dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .checksum(checksum)
  );

  result_drain #(.ROW_MAJOR(1'b0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .ram_rd_en(ram_rd_en2), .ram_addr(ram_addr2), .ram_rd_data(ram_rd_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_row(out_row2), .out_col(out_col2), .out_last(out_last2), .checksum(checksum2)
  );

  // Registered-read RAM models
  always @(posedge clk) if (ram_rd_en)  ram_rd_data  <= mem[ram_addr];
  always @(posedge clk) if (ram_rd_en2) ram_rd_data2 <= mem2[ram_addr2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Row-major element k is matrix entry (k/8, k%8), stored column-major at 8*col+row.
  function automatic logic [25:0] exp_elem(input int k);
    int r;
    int c;
    r = k / 8;
    c = k % 8;
    return {mem[8 * c + r], 3'(r), 3'(c), (k == 63)};
  endfunction

  function automatic int mem_sum();
    int s;
    s = 0;
    for (int a = 0; a < 64; a++) s += int'($signed(mem[a]));
    return s;
  endfunction

  typedef struct {
    string name;
    int    mode;         // 0 ready high, 1 toggle, 2 20-cycle stall, 3 random
    int    pat;          // 0 mem[a]=a, 1 all most-negative, 2 random
    int    restart_at;   // cycle of a spurious start, -1 none
    int    reset_after;  // element index after whose handshake reset is pulsed, -1 none
    bit    timing;       // check exact cycle timing
    bit    use_model;    // expected checksum from model sum
    int    exp_cs;
  } vec_t;

  vec_t vecs[9];

  int n_hs, n_done, done_cyc, cs_done, cs_after, n_rd;
  int first_rd, last_rd, first_v, last_v, first_b, last_b, last_flag_cyc;
  int stall_rd, late_rd, rst_seen;

  task automatic run_stream(input vec_t v);
    int          stall_start;
    int          rst_cyc;
    bit          prev_hold;
    logic [26:0] snap;
    stall_start = -1; rst_cyc = -1; prev_hold = 1'b0; snap = '0;
    n_hs = 0; n_done = 0; done_cyc = -1; cs_done = 0; cs_after = 0; n_rd = 0;
    first_rd = -1; last_rd = -1; first_v = -1; last_v = -1; first_b = -1; last_b = -1;
    last_flag_cyc = -1; stall_rd = 0; late_rd = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (c == v.restart_at) || (c == rst_cyc);
      reset = !(c == rst_cyc);
      case (v.mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 2 == 0);
        2:       out_ready = !(stall_start >= 0 && c >= stall_start && c < stall_start + 20);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      if (ram_rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        if (stall_start >= 0 && c >= stall_start && c < stall_start + 20) begin
          stall_rd++;
          if (c >= stall_start + 3) late_rd++;
        end
      end
      if (busy) begin
        if (first_b < 0) first_b = c;
        last_b = c;
      end
      if (out_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (out_last) last_flag_cyc = c;
      if (prev_hold && c != rst_cyc + 1)
        check($sformatf("%s_hold_c%0d", v.name, c),
              {out_valid, out_data, out_row, out_col, out_last} == snap,
              longint'({out_valid, out_data, out_row, out_col, out_last}), longint'(snap));
      if (out_valid && out_ready) begin
        if (n_hs < 64)
          check($sformatf("%s_elem%0d", v.name, n_hs),
                {out_data, out_row, out_col, out_last} == exp_elem(n_hs),
                longint'({out_data, out_row, out_col, out_last}), longint'(exp_elem(n_hs)));
        else
          check($sformatf("%s_extra_elem", v.name), 1'b0, n_hs, 63);
        n_hs++;
        if (v.mode == 2 && n_hs == 11 && stall_start < 0) stall_start = c + 1;
        if (v.reset_after >= 0 && n_hs == v.reset_after + 1 && rst_cyc < 0) rst_cyc = c + 1;
      end
      prev_hold = out_valid && !out_ready;
      snap = {out_valid, out_data, out_row, out_col, out_last};
      if (done) begin
        n_done++;
        done_cyc = c;
        cs_done = int'($signed(checksum));
      end
      if (rst_cyc >= 0 && c == rst_cyc + 1)
        check($sformatf("%s_reset_clear", v.name),
              {out_valid, busy, done, ram_rd_en, checksum} == '0,
              longint'({out_valid, busy, done, ram_rd_en, checksum}), 0);
      if (rst_cyc >= 0 && c == rst_cyc + 12) break;
      if (done_cyc >= 0 && c == done_cyc + 2) begin
        cs_after = int'($signed(checksum));
        break;
      end
    end
    rst_seen = rst_cyc;
    start = 1'b0;
    reset = 1'b1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int exp_cs;
    int k2;
    int cs2;
    bit d2;
    logic [25:0] e2;

    vecs[0] = '{"rowmaj",       0, 0, -1, -1, 1'b1, 1'b0, 2016};
    vecs[1] = '{"toggle",       1, 0, -1, -1, 1'b0, 1'b0, 2016};
    vecs[2] = '{"stall20",      2, 0, -1, -1, 1'b0, 1'b0, 2016};
    vecs[3] = '{"all_min",      0, 1, -1, -1, 1'b1, 1'b0, -16777216};
    vecs[4] = '{"restart_busy", 0, 0, 20, -1, 1'b1, 1'b0, 2016};
    vecs[5] = '{"reset_mid",    0, 0, -1, 30, 1'b0, 1'b0, 0};
    vecs[6] = '{"after_reset",  0, 0, -1, -1, 1'b1, 1'b0, 2016};
    vecs[7] = '{"random_a",     3, 2, -1, -1, 1'b0, 1'b1, 0};
    vecs[8] = '{"random_b",     3, 2, -1, -1, 1'b0, 1'b1, 0};

    for (int a = 0; a < 64; a++) mem2[a] = 19'(a);

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state",
          {busy, done, ram_rd_en, out_valid, out_data, out_row, out_col, out_last, checksum} == '0,
          longint'({busy, done, ram_rd_en, out_valid, checksum}), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      for (int a = 0; a < 64; a++) begin
        case (vecs[i].pat)
          0:       mem[a] = 19'(a);
          1:       mem[a] = 19'h40000;
          default: mem[a] = 19'($urandom);
        endcase
      end
      exp_cs = vecs[i].use_model ? mem_sum() : vecs[i].exp_cs;
      run_stream(vecs[i]);
      if (vecs[i].reset_after < 0) begin
        check({vecs[i].name, "_count"}, n_hs == 64, n_hs, 64);
        check({vecs[i].name, "_done_once"}, n_done == 1, n_done, 1);
        check({vecs[i].name, "_checksum"}, cs_done == exp_cs, cs_done, exp_cs);
        check({vecs[i].name, "_checksum_hold"}, cs_after == exp_cs, cs_after, exp_cs);
        check({vecs[i].name, "_reads"}, n_rd == 64, n_rd, 64);
        if (vecs[i].mode == 2) begin
          check("stall_reads", stall_rd <= 2, stall_rd, 2);
          check("stall_late_reads", late_rd == 0, late_rd, 0);
        end
        if (vecs[i].timing) begin
          check({vecs[i].name, "_rd_first"}, first_rd == 1, first_rd, 1);
          check({vecs[i].name, "_rd_last"}, last_rd == 64, last_rd, 64);
          check({vecs[i].name, "_valid_first"}, first_v == 3, first_v, 3);
          check({vecs[i].name, "_valid_last"}, last_v == 66, last_v, 66);
          check({vecs[i].name, "_last_cyc"}, last_flag_cyc == 66, last_flag_cyc, 66);
          check({vecs[i].name, "_done_cyc"}, done_cyc == 67, done_cyc, 67);
          check({vecs[i].name, "_busy_first"}, first_b == 1, first_b, 1);
          check({vecs[i].name, "_busy_last"}, last_b == 66, last_b, 66);
        end
      end else begin
        check({vecs[i].name, "_no_done"}, n_done == 0, n_done, 0);
        check({vecs[i].name, "_count"}, n_hs == vecs[i].reset_after + 2, n_hs, vecs[i].reset_after + 2);
        check({vecs[i].name, "_start_ignored"}, last_b == rst_seen, last_b, rst_seen);
      end
    end

    // Plain address order instance
    k2 = 0; cs2 = 0; d2 = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk); #1;
      start2 = (c == 0);
      @(negedge clk);
      if (out_valid2 && out_ready2) begin
        e2 = {19'(k2), 3'(k2 % 8), 3'(k2 / 8), (k2 == 63)};
        if (k2 < 64)
          check($sformatf("plain_elem%0d", k2), {out_data2, out_row2, out_col2, out_last2} == e2,
                longint'({out_data2, out_row2, out_col2, out_last2}), longint'(e2));
        k2++;
      end
      if (done2) begin
        cs2 = int'($signed(checksum2));
        d2 = 1'b1;
        break;
      end
    end
    check("plain_count", k2 == 64, k2, 64);
    check("plain_done", d2, d2, 1);
    check("plain_checksum", cs2 == 2016, cs2, 2016);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Downstream stage of the 8x8 signed matrix multiplier.
- Once the multiplier asserts done, this block reads the 64-entry 19-bit result RAM, which is stored column-major (element row r, col c at address 8*c+r).
- It streams the elements out over a valid/ready interface in row-major order, with row/col tags and a last flag.
- It also accumulates a signed checksum that the bench can use for fast pass/fail.

Parameters:
- DIM, 8, matrix dimension; must be a power of two.
- DATA_W, 19, result element width, signed.
- ADDR_W, 6, result RAM address width; equals 2*log2(DIM).
- CHK_W, 25, checksum width; equals DATA_W + ADDR_W.
- ROW_MAJOR, 1, 1 = emit in row-major order (transpose the addressing); 0 = emit in plain address order.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; driven by the multiplier done.
- busy  out  1  high from the cycle after start is accepted until the final handshake.
- done  out  1  one-cycle pulse, the cycle after the final handshake.
- ram_rd_en  out  1  read strobe to the result RAM.
- ram_addr  out  ADDR_W  read address.
- ram_rd_data  in  DATA_W  signed; registered read, valid the cycle after ram_rd_en.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  DATA_W  signed element.
- out_row  out  3  row index of out_data.
- out_col  out  3  column index of out_data.
- out_last  out  1  high with element index 63.
- checksum  out  CHK_W  signed sum of all accepted elements.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state returns to IDLE; FIFO and counters are cleared.
  - All outputs go to 0, including checksum.
  - Any stream in progress is abandoned and done is not pulsed.
- States:
  - IDLE -> RUN on start.
  - RUN -> DRAIN once the read index has issued 63.
  - DRAIN -> FIN once the FIFO is empty and no read is in flight after the handshake of element 63.
  - FIN -> IDLE unconditionally; done=1 only in FIN.
- start outside IDLE is ignored.
- Accepting start clears checksum and both the read and emit indices.
- Index n (6 bits) counts 0..63:
  - ROW_MAJOR=1: r=n[5:3], c=n[2:0], ram_addr={c,r}.
  - ROW_MAJOR=0: ram_addr=n, r=n[2:0], c=n[5:3].
  - out_row/out_col carry r/c with each element; tags travel through the FIFO alongside the data.
- Buffering:
  - 2-entry FIFO of {data, row, col, last}.
  - A read issues only when (FIFO occupancy + reads in flight) < 2, so there is never an overflow and never a RAM re-read.
  - out_* is driven from the FIFO head.
  - While out_valid && !out_ready, out_data, out_row, out_col and out_last hold stable.
  - out_valid never drops without a handshake, except on reset.
- Throughput: one element per cycle while out_ready is held high.
- Timing, with start high in cycle 0 and out_ready tied high:
  - ram_rd_en is high in cycles 1..64.
  - out_valid is high in cycles 3..66.
  - out_last is high in cycle 66.
  - done is high in cycle 67.
  - busy is high in cycles 1..66.
- Checksum:
  - On each handshake, checksum += sign-extended out_data.
  - CHK_W is sized so that 64 values can never overflow.
  - The value is final when done pulses and holds until the next start or reset.
- Simultaneous events:
  - A handshake and a FIFO write in the same cycle are both honoured; occupancy is unchanged.
  - reset low dominates start.

Decomposition:
- Package mm_pkg holds:
  - DIM, DATA_W, ADDR_W, CHK_W.
  - The state enum {IDLE, RUN, DRAIN, FIN}.
  - A packed struct for FIFO entries {data, row, col, last}.
- One natural sub-module, drain_fifo2: a 2-entry synchronous FIFO with push/pop/full/empty/count, using the same clk and active-low synchronous reset.
- The top level contains the FSM, index generation, in-flight tracking and checksum.

Test Plan:
1. RAM mem[a]=a, out_ready=1, pulse start:
   - out_data sequence is 0,8,16,...,56,1,9,...,63 with (row,col) = (0,0),(0,1)...
   - out_valid is high in cycles 3..66; done pulses in cycle 67; checksum=2016.
2. Same RAM, out_ready toggling 1,0,1,0:
   - Identical order, with no drops or duplicates.
   - Output held stable during each stall.
   - out_last only on value 63; checksum=2016.
3. out_ready held low for 20 cycles starting after element 10:
   - At most 2 reads issue after the stall begins; ram_rd_en then stays 0.
   - Streaming resumes with element 11; 64 elements total.
4. All RAM entries = -262144: each out_data = -262144; checksum = -16777216, with no overflow.
5. Pulse start again while busy: ignored, and the stream is unchanged.
6. Assert reset low after the handshake of element 30:
   - Next cycle out_valid=0, busy=0, checksum=0, and no done pulse.
   - A subsequent start produces a full 64-element stream.
7. ROW_MAJOR=0 with mem[a]=a: out_data = 0,1,2,...,63 in order; checksum=2016.
